// File: rtl/int_to_float_pkg.sv
// Shared IEEE-754 single-precision field widths, constants and the packed result layout
// used by the integer-to-float pipeline.
package int_to_float_pkg;
  localparam int          FP_EXP_W  = 8;
  localparam int          FP_MANT_W = 23;
  localparam int          FP_BIAS   = 127;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;
endpackage

// File: rtl/leading_zero_count.sv
// Combinational leading-zero counter; count = WIDTH and all_zero = 1 for an all-zero vector.
// No state, no handshake.
module leading_zero_count #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|vec;

endmodule

// File: rtl/int_to_float_pipe.sv
// Integer to IEEE-754 single converter, round-nearest-even; 3-cycle latency, 1 sample/cycle.
// Backpressure: every stage holds while the output is valid and unaccepted; ready_in follows that advance.
module int_to_float_pipe
  import int_to_float_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int SIGNED_IN = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] data_in,
  input  logic                valid_in,
  output logic                ready_in,
  output logic [31:0]         float_out,
  output logic                inexact_out,
  output logic                valid_out,
  input  logic                ready_out
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int REM_W = IN_WIDTH - 1;
  localparam int EXT_W = REM_W + FP_MANT_W + 1;

  logic adv;
  assign adv      = !valid_out || ready_out;
  assign ready_in = adv;

  // ---------------- S1: sign / magnitude ----------------
  logic                in_sign;
  logic [IN_WIDTH-1:0] in_mag;

  assign in_sign = (SIGNED_IN != 0) && data_in[IN_WIDTH-1];
  // Most-negative input negates to 2^(IN_WIDTH-1), which still fits unsigned.
  assign in_mag  = in_sign ? (~data_in + IN_WIDTH'(1)) : data_in;

  logic                s1_vld;
  logic                s1_sign;
  logic [IN_WIDTH-1:0] s1_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
    end else if (adv) begin
      s1_vld  <= valid_in;
      s1_sign <= in_sign;
      s1_mag  <= in_mag;
    end
  end

  // ---------------- S2: normalise ----------------
  logic [CNT_W-1:0]    s1_lz;
  logic                s1_zero;
  logic [IN_WIDTH-1:0] s1_norm;
  logic [7:0]          s1_msb;

  leading_zero_count #(
    .WIDTH (IN_WIDTH),
    .CNT_W (CNT_W)
  ) u_lzc (
    .vec      (s1_mag),
    .count    (s1_lz),
    .all_zero (s1_zero)
  );

  assign s1_norm = s1_mag << s1_lz;
  assign s1_msb  = 8'(IN_WIDTH - 1) - 8'(s1_lz);

  logic             s2_vld;
  logic             s2_sign;
  logic             s2_zero;
  logic [7:0]       s2_msb;
  logic [REM_W-1:0] s2_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b1;
      s2_msb  <= '0;
      s2_rem  <= '0;
    end else if (adv) begin
      s2_vld  <= s1_vld;
      s2_sign <= s1_sign;
      s2_zero <= s1_zero;
      s2_msb  <= s1_msb;
      s2_rem  <= s1_norm[REM_W-1:0];
    end
  end

  // ---------------- S3: round / pack ----------------
  // Bits below the hidden one, zero-padded so narrow inputs give G=S=0.
  logic [EXT_W-1:0]     ext;
  logic [FP_MANT_W-1:0] frac;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic                 carry;
  logic [FP_MANT_W-1:0] frac_r;
  logic [FP_EXP_W-1:0]  exp_r;
  fp32_t                res;
  logic                 res_inexact;

  assign ext      = {s2_rem, {(FP_MANT_W + 1){1'b0}}};
  assign frac     = ext[EXT_W-1 -: FP_MANT_W];
  assign guard    = ext[EXT_W-1-FP_MANT_W];
  assign sticky   = |ext[EXT_W-2-FP_MANT_W:0];
  assign round_up = guard && (sticky || frac[0]);

  // A carry out of the mantissa leaves frac_r = 0 and bumps the exponent.
  assign {carry, frac_r} = {1'b0, frac} + {{FP_MANT_W{1'b0}}, round_up};
  assign exp_r = 8'(FP_BIAS) + s2_msb + {7'b0, carry};

  always_comb begin
    res         = fp32_t'(FP32_ZERO);
    res_inexact = 1'b0;
    if (!s2_zero) begin
      res.sign    = s2_sign;
      res.exp     = exp_r;
      res.mant    = frac_r;
      res_inexact = guard | sticky;
    end
  end

  fp32_t out_q;
  logic  out_inexact;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out   <= 1'b0;
      out_q       <= fp32_t'(FP32_ZERO);
      out_inexact <= 1'b0;
    end else if (adv) begin
      valid_out <= s2_vld;
      if (s2_vld) begin
        out_q       <= res;
        out_inexact <= res_inexact;
      end
    end
  end

  assign float_out   = out_q;
  assign inexact_out = out_inexact;

endmodule

// File: tb/tb_int_to_float_pipe.sv
// Bench for int_to_float_pipe: three configurations (u32, s32, s8) driven from one shared stream,
// directed vector table, backpressure and reset sequences, plus randomized traffic vs an arithmetic model.
module tb_int_to_float_pipe;

  logic        clk;
  logic        reset_n;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;

  logic        rdy_u, rdy_s, rdy_8;
  logic [31:0] f_u, f_s, f_8;
  logic        ix_u, ix_s, ix_8;
  logic        vo_u, vo_s, vo_8;

  int n_cmp  = 0;
  int n_fail = 0;

  int_to_float_pipe #(.IN_WIDTH(32), .SIGNED_IN(0)) u_u32 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_u),
    .float_out(f_u), .inexact_out(ix_u), .valid_out(vo_u), .ready_out(ready_out));

  int_to_float_pipe #(.IN_WIDTH(32), .SIGNED_IN(1)) u_s32 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .valid_in(valid_in), .ready_in(rdy_s),
    .float_out(f_s), .inexact_out(ix_s), .valid_out(vo_s), .ready_out(ready_out));

  int_to_float_pipe #(.IN_WIDTH(8), .SIGNED_IN(1)) u_s8 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in[7:0]), .valid_in(valid_in), .ready_in(rdy_8),
    .float_out(f_8), .inexact_out(ix_8), .valid_out(vo_8), .ready_out(ready_out));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact rational rounding from magnitude, quotient and remainder.
  function automatic logic [32:0] model(input logic [31:0] raw, input int width, input bit sgn);
    longint v, mag, q, rem, half;
    bit     neg, ix;
    int     msb, sh, e;
    v   = longint'(raw) & ((longint'(1) << width) - 1);
    neg = sgn && v[width-1];
    mag = neg ? ((longint'(1) << width) - v) : v;
    if (mag == 0) return 33'd0;
    msb = 0;
    for (int i = 0; i < 40; i++) if (mag >= (longint'(1) << i)) msb = i;
    ix = 1'b0;
    if (msb <= 23) begin
      q = mag << (23 - msb);
    end else begin
      sh   = msb - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      ix   = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q   = q >> 1;
        msb = msb + 1;
      end
    end
    e = 127 + msb;
    return {ix, neg, 8'(e), q[22:0]};
  endfunction

  // Scoreboard: inputs and outputs sampled mid-cycle, ahead of the edge they transfer on.
  logic [32:0] qu[$], qs[$], q8[$];
  logic [32:0] ev;

  always @(negedge clk) begin
    if (!reset_n) begin
      qu.delete(); qs.delete(); q8.delete();
    end else begin
      if (vo_u && ready_out) begin
        if (qu.size() == 0) check("sb_u32_extra", 64'd1, 64'd0);
        else begin ev = qu.pop_front(); check("sb_u32", {31'd0, ix_u, f_u}, {31'd0, ev}); end
      end
      if (vo_s && ready_out) begin
        if (qs.size() == 0) check("sb_s32_extra", 64'd1, 64'd0);
        else begin ev = qs.pop_front(); check("sb_s32", {31'd0, ix_s, f_s}, {31'd0, ev}); end
      end
      if (vo_8 && ready_out) begin
        if (q8.size() == 0) check("sb_s8_extra", 64'd1, 64'd0);
        else begin ev = q8.pop_front(); check("sb_s8", {31'd0, ix_8, f_8}, {31'd0, ev}); end
      end
      if (valid_in && rdy_u) begin
        qu.push_back(model(data_in, 32, 1'b0));
        qs.push_back(model(data_in, 32, 1'b1));
        q8.push_back(model(data_in, 8, 1'b1));
      end
    end
  end

  function automatic logic [33:0] sel_out(input int cfg);
    case (cfg)
      0:       return {vo_u, ix_u, f_u};
      1:       return {vo_s, ix_s, f_s};
      default: return {vo_8, ix_8, f_8};
    endcase
  endfunction

  // One isolated sample: valid_out must rise exactly in the third cycle after the input cycle.
  task automatic run_vec(input int cfg, input logic [31:0] din, input logic [31:0] ef,
                         input logic eix, input string nm);
    logic [33:0] o;
    bit early;
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = din;
    @(posedge clk); #1;
    valid_in = 1'b0;
    early = sel_out(cfg)[33];
    @(posedge clk); #1;
    early = early | sel_out(cfg)[33];
    @(posedge clk); #1;
    o = sel_out(cfg);
    check({nm, "_latency"}, {62'd0, early, o[33]}, 64'd1);
    check({nm, "_float"}, {32'd0, o[31:0]}, {32'd0, ef});
    check({nm, "_inexact"}, {63'd0, o[32]}, {63'd0, eix});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(5))
      0:       return $urandom;
      1:       return 32'($urandom_range(300));
      2:       return 32'h0100_0000 + 32'($urandom_range(64));
      3:       return 32'h0 - 32'($urandom_range(100000));
      4:       return 32'd1 << $urandom_range(31);
      default: return (32'($urandom_range(255)) << 24) | 32'h0080_0000 | 32'($urandom_range(3));
    endcase
  endfunction

  typedef struct {
    int          cfg;
    logic [31:0] din;
    logic [31:0] f;
    logic        ix;
  } vec_t;

  vec_t        tbl[16];
  logic [31:0] bp_vals[5];
  logic [31:0] held;
  int          sent, got;
  bit          seen, pend;

  initial begin
    tbl[0]  = '{0, 32'd0,        32'h0000_0000, 1'b0};
    tbl[1]  = '{0, 32'd1,        32'h3F80_0000, 1'b0};
    tbl[2]  = '{0, 32'd255,      32'h437F_0000, 1'b0};
    tbl[3]  = '{0, 32'd16777216, 32'h4B80_0000, 1'b0};
    tbl[4]  = '{0, 32'd16777217, 32'h4B80_0000, 1'b1};
    tbl[5]  = '{0, 32'd16777219, 32'h4B80_0002, 1'b1};
    tbl[6]  = '{0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1};
    tbl[7]  = '{1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
    tbl[8]  = '{1, 32'h8000_0000, 32'hCF00_0000, 1'b0};
    tbl[9]  = '{1, 32'hFEFF_FFFF, 32'hCB80_0000, 1'b1};
    tbl[10] = '{1, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1};
    tbl[11] = '{1, 32'd0,        32'h0000_0000, 1'b0};
    tbl[12] = '{2, 32'h0000_0080, 32'hC300_0000, 1'b0};
    tbl[13] = '{2, 32'h0000_007F, 32'h42FE_0000, 1'b0};
    tbl[14] = '{2, 32'h0000_00FF, 32'hBF80_0000, 1'b0};
    tbl[15] = '{0, 32'h8000_0000, 32'h4F00_0000, 1'b0};
    bp_vals = '{32'd3, 32'd16777219, 32'd1000, 32'hFFFF_FFFF, 32'd7};

    reset_n   = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    data_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {28'd0, vo_u, ix_u, rdy_u, vo_8, f_u}, {28'd0, 4'b0010, 32'h0});
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run_vec(tbl[i].cfg, tbl[i].din, tbl[i].f, tbl[i].ix, $sformatf("vec%0d", i));

    // Backpressure: five back-to-back values, output stalled in cycles 4..9.
    sent = 0;
    got  = 0;
    held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      ready_out = !(cyc >= 4 && cyc < 10);
      valid_in  = (sent < 5);
      data_in   = (sent < 5) ? bp_vals[sent] : 32'd0;
      @(negedge clk);
      if (cyc == 4) held = f_u;
      if (cyc == 5 || cyc == 9)
        check($sformatf("bp_hold_c%0d", cyc), {30'd0, vo_u, rdy_u, f_u}, {30'd0, 2'b10, held});
      if (valid_in && rdy_u) sent++;
      if (vo_u && ready_out) got++;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    check("bp_counts", {32'(sent), 32'(got)}, {32'd5, 32'd5});
    check("bp_drained", 64'(qu.size()), 64'd0);

    // Reset with three samples in flight.
    ready_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid_in = 1'b1;
      data_in  = 32'd100 + 32'(k);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    check("rst_mid_before", {63'd0, vo_u}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outs", {29'd0, vo_u, ix_u, rdy_u, f_u}, {29'd0, 3'b001, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n   = 1'b1;
    ready_out = 1'b1;
    seen      = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (vo_u || vo_s || vo_8) seen = 1'b1;
    end
    check("rst_mid_quiet", {63'd0, seen}, 64'd0);
    run_vec(0, 32'd255, 32'h437F_0000, 1'b0, "post_rst");

    // Randomized traffic with random stalls; data held while offered and not accepted.
    pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ready_out = ($urandom_range(3) != 0);
      if (!pend) begin
        valid_in = ($urandom_range(3) != 0);
        data_in  = rand_val();
      end
      @(negedge clk);
      pend = valid_in && !rdy_u;
      @(posedge clk); #1;
    end
    valid_in  = 1'b0;
    ready_out = 1'b1;
    for (int w = 0; w < 20 && qu.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    check("rand_drained", {32'(qu.size()), 32'(q8.size())}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/int_to_float_pipe.md
Name: int_to_float_pipe

Overview:
- Parametrised, pipelined converter from a W-bit integer (signed or unsigned) to IEEE-754 single precision.
- Rounds to nearest, ties to even, and flags inexact results.
- Uses a valid/ready handshake on both sides and accepts one sample per cycle when the output is not stalled.
- Sits between the integer histogram/statistics stages and the floating-point threshold arithmetic.

Parameters:
IN_WIDTH, 32, input integer width; legal range 2..32
SIGNED_IN, 0, 1 = treat data_in as two's complement; 0 = unsigned

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
data_in  in  IN_WIDTH  integer operand
valid_in  in  1  data_in is valid this cycle
ready_in  out  1  block can accept data_in this cycle
float_out  out  32  IEEE-754 single result
inexact_out  out  1  result was rounded (1) or is exact (0)
valid_out  out  1  float_out/inexact_out are valid
ready_out  in  1  downstream accepts the result this cycle

Behaviour:
- Reset: asynchronous, active-low; all stage valid bits 0, float_out=0, inexact_out=0, valid_out=0.
  - Asserting reset_n low mid-operation discards every in-flight sample; nothing emerges after release.
- Handshake:
  - Transfer in when valid_in && ready_in; transfer out when valid_out && ready_out.
  - adv = !valid_out || ready_out; ready_in = adv (combinational).
  - When adv=0, all stages hold, and float_out/inexact_out stay stable while valid_out=1.
  - Bubbles propagate as valid=0.
- Latency: exactly 3 cycles from input transfer to valid_out, with no stall. Throughput is 1/cycle.
  - Order is preserved. Up to 3 samples can be in flight.
- S1 (sign/magnitude):
  - sign = SIGNED_IN & data_in[IN_WIDTH-1].
  - mag = sign ? (~data_in + 1) : data_in, held in IN_WIDTH unsigned bits.
  - The most-negative value yields mag = 2^(IN_WIDTH-1) with no overflow.
- S2 (normalise):
  - lz = leading-zero count of mag; msb = IN_WIDTH-1-lz.
  - norm = mag << lz, left-justified so the leading 1 is dropped as the hidden bit.
  - zero flag = (mag==0).
- S3 (round/pack):
  - frac = 23 bits below the leading 1. If msb<=23, frac is zero-padded and exact (G=R=S=0).
  - Otherwise G = first dropped bit, and S = OR of the remaining dropped bits.
  - round_up = G && (S || frac[0]).
  - frac+round_up carrying out of 23 bits sets frac=0 and exp+1.
  - exp = 127 + msb (+carry).
  - float_out = {sign, exp[7:0], frac}; inexact_out = G|S.
  - zero: float_out = 32'h0000_0000 (never -0), inexact_out = 0.
- Range: with IN_WIDTH<=32, exp never exceeds 127+32, so no infinity or NaN is produced.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.

Decomposition:
- Package int_to_float_pkg holds:
  - constants FP_EXP_W=8, FP_MANT_W=23, FP_BIAS=127, FP32_ZERO=32'h0;
  - a packed struct fp32_t {sign, exp, mant}.
- Sub-module leading_zero_count (parameter WIDTH), purely combinational. It returns the count and an all_zero flag and is instantiated in S2.
- The remaining logic stays in int_to_float_pipe.

Test Plan:
- Unsigned, IN_WIDTH=32, no stall. Inputs 0, 1, 255, 16777216 -> 32'h00000000/0, 32'h3F800000/0, 32'h437F0000/0, 32'h4B800000/0. Each output appears 3 cycles after its input.
- Rounding, unsigned. Inputs:
  - 16777217 -> 32'h4B800000, inexact=1 (tie to even, down);
  - 16777219 -> 32'h4B800002, inexact=1 (tie to even, up);
  - 32'hFFFFFFFF -> 32'h4F800000, inexact=1 (mantissa carry into exponent).
- SIGNED_IN=1, IN_WIDTH=32. Inputs -1 -> 32'hBF800000; 32'h80000000 -> 32'hCF000000 exact; -16777217 -> 32'hCB800000 inexact.
- IN_WIDTH=8, SIGNED_IN=1. Input 8'h80 (-128) -> 32'hC3000000; 8'h7F -> 32'h42FE0000; both exact.
- Backpressure:
  - Stream 5 back-to-back values and hold ready_out=0 from cycle 4.
  - Required: valid_out=1 with a stable float_out, and ready_in=0.
  - On release, all 5 results emerge in order with none dropped or duplicated.
- Reset mid-stream: pull reset_n low with 3 samples in flight, then release. All outputs are 0 immediately; valid_out stays 0 until a new input is accepted, and then appears 3 cycles later.
